// File: rtl/ssd_scan.sv
// Four-digit time-multiplexed seven-segment scanner with dead-time and tear-free frame updates.
// Optional blink support is compiled in when SSD_BLINK_EN is defined.
module ssd_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam int MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  typedef enum logic {ST_DEAD, ST_SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             boundary;

  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_blank_q, disp_blank_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_blank_q, pend_blank_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_flag_q, pend_flag_d;
  logic        has_pend;

  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;
  logic [3:0] eff_blank;
  logic       lit;

  // Sequencer: DEAD -> SHOW -> (advance digit) -> DEAD ...
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    digit_d  = digit_q;
    boundary = 1'b0;
    case (state_q)
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d    = '0;
          digit_d  = digit_q + 2'd1;
          state_d  = (DEAD_CYCLES == 0) ? ST_SHOW : ST_DEAD;
          boundary = (digit_q == 2'd3);
        end
      end
      default: state_d = ST_DEAD;
    endcase
  end

  // A load on the boundary cycle itself folds into the same copy.
  always_comb begin
    has_pend     = load | pend_flag_q;
    pend_val_d   = load ? value : pend_val_q;
    pend_blank_d = load ? blank : pend_blank_q;
    pend_dp_d    = load ? dp_in : pend_dp_q;
    pend_flag_d  = has_pend & ~boundary;
    disp_val_d   = (boundary && has_pend) ? pend_val_d   : disp_val_q;
    disp_blank_d = (boundary && has_pend) ? pend_blank_d : disp_blank_q;
    disp_dp_d    = (boundary && has_pend) ? pend_dp_d    : disp_dp_q;
  end

`ifdef SSD_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (boundary) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign eff_blank = disp_blank_d | (phase_d ? blink_mask : 4'h0);
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES == 0);
  assign eff_blank    = disp_blank_d;
`endif

  // Outputs are registered from next-state so they line up with the state they describe.
  always_comb begin
    lit  = (state_d == ST_SHOW) && !eff_blank[digit_d];
    an_d = lit ? ~(4'b0001 << digit_d) : 4'b1111;
    dp_d = lit ? ~disp_dp_d[digit_d] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DEAD;
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      disp_val_q   <= '0;
      disp_blank_q <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= 4'b1111;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      disp_val_q   <= disp_val_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  // num follows digit_sel with no register so the decoder settles during DEAD.
  assign num        = disp_val_q[{digit_q, 2'b00} +: 4];
  assign an         = an_q;
  assign dp         = dp_q;
  assign digit_sel  = digit_q;
  assign frame_done = boundary;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan with REFRESH_DIV=4, DEAD_CYCLES=2, BLINK_FRAMES=2 (24-cycle frames).
module tb_ssd_scan;

  logic        clk, rst, load;
  logic [15:0] value;
  logic [3:0]  blank, dp_in, blink_mask;
  logic [3:0]  num, an;
  logic        dp, frame_done;
  logic [1:0]  digit_sel;

  ssd_scan #(.REFRESH_DIV(4), .DEAD_CYCLES(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank(blank),
    .dp_in(dp_in), .blink_mask(blink_mask), .num(num), .an(an), .dp(dp),
    .digit_sel(digit_sel), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [3:0] num;
    logic       dp;
    logic       fd;
    logic [1:0] sel;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int kc       = 0;   // cycles since reset release, sampled on negedge

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    kc++;
  endtask

  task automatic goto(input int k);
    while (kc < k) step();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, kc, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    goto(v.k);
    chk({tag, ".an"},  an,         v.an);
    chk({tag, ".num"}, num,        v.num);
    chk({tag, ".dp"},  dp,         v.dp);
    chk({tag, ".fd"},  frame_done, v.fd);
    chk({tag, ".sel"}, digit_sel,  v.sel);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    load = 1'b1; value = v; blank = b; dp_in = d;
    $display("k=%0d load value=%h blank=%b dp_in=%b", kc, v, b, d);
    step();
    load = 1'b0;
  endtask

  vec_t rel_tbl[10];
  vec_t f1_tbl[5];

  initial begin
    logic [3:0] exp_an;
    logic       dark;

    rel_tbl[0] = '{0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0};
    rel_tbl[1] = '{1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0};
    rel_tbl[2] = '{2, 4'hE, 4'h0, 1'b1, 1'b0, 2'd0};
    rel_tbl[3] = '{3, 4'hE, 4'h0, 1'b1, 1'b0, 2'd0};
    rel_tbl[4] = '{4, 4'hE, 4'h0, 1'b1, 1'b0, 2'd0};
    rel_tbl[5] = '{5, 4'hE, 4'h0, 1'b1, 1'b0, 2'd0};
    rel_tbl[6] = '{6, 4'hF, 4'h0, 1'b1, 1'b0, 2'd1};
    rel_tbl[7] = '{7, 4'hF, 4'h0, 1'b1, 1'b0, 2'd1};
    rel_tbl[8] = '{8, 4'hD, 4'h0, 1'b1, 1'b0, 2'd1};
    rel_tbl[9] = '{9, 4'hD, 4'h0, 1'b1, 1'b0, 2'd1};

    // Frame 1 after loading 1A3F with dp on digit 2.
    f1_tbl[0] = '{24, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0};
    f1_tbl[1] = '{27, 4'hE, 4'hF, 1'b1, 1'b0, 2'd0};
    f1_tbl[2] = '{33, 4'hD, 4'h3, 1'b1, 1'b0, 2'd1};
    f1_tbl[3] = '{39, 4'hB, 4'hA, 1'b0, 1'b0, 2'd2};
    f1_tbl[4] = '{45, 4'h7, 4'h1, 1'b1, 1'b0, 2'd3};

    rst = 1'b1; load = 1'b0; value = '0; blank = '0; dp_in = '0; blink_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst.an", an, 4'hF);
    chk("rst.dp", dp, 1'b1);
    chk("rst.num", num, 4'h0);
    chk("rst.fd", frame_done, 1'b0);
    chk("rst.sel", digit_sel, 2'd0);
    rst = 1'b0;
    kc  = 0;

    for (int i = 0; i < 10; i++) chk_vec("rel", rel_tbl[i]);

    // Mid-frame load must not tear the current frame.
    goto(10);
    do_load(16'h1A3F, 4'b0000, 4'b0100);
    goto(15);
    chk("tear.num", num, 4'h0);
    chk("tear.an", an, 4'hB);
    goto(23);
    chk("f0.fd", frame_done, 1'b1);
    chk("f0.num", num, 4'h0);
    for (int i = 0; i < 5; i++) chk_vec("f1", f1_tbl[i]);

    // Multiple loads: last wins, boundary-cycle load included.
    goto(50);
    do_load(16'h1111, 4'b0000, 4'b0000);
    chk("multi.num", num, 4'hF);
    goto(60);
    do_load(16'h2222, 4'b0000, 4'b0000);
    goto(71);
    chk("bnd.fd", frame_done, 1'b1);
    do_load(16'h3333, 4'b0000, 4'b0000);
    chk("f3.dead.num", num, 4'h3);
    for (int d = 0; d < 4; d++) begin
      goto(72 + 3 + 6 * d);
      exp_an = ~(4'b0001 << d);
      chk("f3.num", num, 4'h3);
      chk("f3.an", an, exp_an);
      chk("f3.dp", dp, 1'b1);
    end

    // Blanked digit 3 keeps frame timing.
    goto(80);
    do_load(16'h8888, 4'b1000, 4'b0000);
    for (int k = 96; k < 144; k++) begin
      goto(k);
      chk("blank.fd", frame_done, (k % 24) == 23);
      chk("blank.an3", an[3], 1'b1);
      if ((k % 24) >= 18) chk("blank.an", an, 4'hF);
      if ((k % 24) == 21) chk("blank.num", num, 4'h8);
      if ((k % 24) == 9)  chk("blank.an1", an, 4'hD);
    end

    // Reset during digit 2 with a load pending.
    goto(146);
    do_load(16'h5555, 4'b0000, 4'b1111);
    goto(159);
    chk("mid.sel_pre", digit_sel, 2'd2);
    rst = 1'b1;
    blink_mask = 4'b0001;
    #1;
    chk("mid.an", an, 4'hF);
    chk("mid.sel", digit_sel, 2'd0);
    chk("mid.dp", dp, 1'b1);
    chk("mid.num", num, 4'h0);
    chk("mid.fd", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    kc  = 0;

    // Pending value lost; digit 0 blink pattern over six frames.
    for (int n = 0; n < 6; n++) begin
`ifdef SSD_BLINK_EN
      dark = (n == 2) || (n == 3);
`else
      dark = 1'b0;
`endif
      goto(24 * n + 3);
      chk("blink.an0", an, dark ? 4'hF : 4'hE);
      chk("lost.num0", num, 4'h0);
      goto(24 * n + 9);
      chk("lost.an1", an, 4'hD);
      chk("lost.dp1", dp, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
